// File: rtl/sys1_pkg.sv
// Shared definitions for the System 1/2 sound-side controller.
//   irq_state_e  : periodic IRQ handshake state (IDLE -> REQ -> ACK)
//   SND_IRQ_DIV  : default clk_en ticks between periodic IRQs (4 MHz / 60 Hz / 4)
//   addr_hit()   : masked address compare used for the command-latch decode
package sys1_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_REQ  = 2'd1,
        IRQ_ACK  = 2'd2
    } irq_state_e;

    localparam int SND_IRQ_DIV = 16667;

    // True when the address bits selected by mask match the base address.
    function automatic logic addr_hit(input logic [15:0] adr,
                                      input logic [15:0] base,
                                      input logic [15:0] mask);
        return ((adr & mask) == (base & mask));
    endfunction

endpackage

// File: rtl/sys1_snd_ctrl_edge_det.sv
// Registered rise/fall detector.
//   clk, reset : system clock, synchronous active-high reset
//   d_i        : level input
//   rise_o     : d_i is 1 now and was 0 last cycle
//   fall_o     : d_i is 0 now and was 1 last cycle
module edge_det (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic prev_q;

    // Remember the previous level of d_i.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= d_i;
        end
    end

    assign rise_o = d_i & ~prev_q;
    assign fall_o = ~d_i & prev_q;

endmodule

// File: rtl/sys1_snd_ctrl.sv
// Sound-CPU interrupt and command-mailbox controller.
//   clk, reset       : system clock, synchronous active-high reset
//   clk_en           : sound-CPU clock enable, paces the IRQ divider
//   main_wr/main_data: main-CPU command write strobe (level) and byte
//   snd_adr/mx/rd    : sound-CPU bus strobes used to decode latch reads
//   intack/nmiack    : sound-CPU interrupt acknowledges (level)
//   intreq/nmireq    : interrupt requests to the sound CPU
//   cmd_oe/cmd_data  : command latch drive enable and latched byte
//   cmd_pending      : a command is waiting to be read
//   cmd_overrun      : sticky, a command was overwritten unread
//   irq_miss         : one-cycle pulse when a periodic tick is dropped
module sys1_snd_ctrl
    import sys1_pkg::*;
#(
    parameter int          IRQ_DIV  = SND_IRQ_DIV,
    parameter logic [15:0] CMD_BASE = 16'hE000,
    parameter logic [15:0] CMD_MASK = 16'hE000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        main_wr,
    input  logic [7:0]  main_data,
    input  logic [15:0] snd_adr,
    input  logic        snd_mx,
    input  logic        snd_rd,
    input  logic        intack,
    input  logic        nmiack,
    output logic        intreq,
    output logic        nmireq,
    output logic        cmd_oe,
    output logic [7:0]  cmd_data,
    output logic        cmd_pending,
    output logic        cmd_overrun,
    output logic        irq_miss
);

    localparam int             CNT_W    = (IRQ_DIV > 2) ? $clog2(IRQ_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IRQ_DIV - 1);

    logic             rd_sel_s;
    logic             wr_rise_s;
    logic             ia_rise_s;
    logic             na_rise_s;
    logic             rd_fall_s;
    logic             unused_fall_s;
    logic             unused_rise_s;
    logic             unused_ia_fall_s;
    logic             unused_na_fall_s;
    logic             tick_s;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    irq_state_e       state_q;
    logic             intreq_q;
    logic             irq_miss_q;
    logic             nmireq_q;
    logic             cmd_pending_q;
    logic             cmd_overrun_q;
    logic [7:0]       cmd_data_q;

    assign rd_sel_s = snd_mx & snd_rd & addr_hit(snd_adr, CMD_BASE, CMD_MASK);

    edge_det u_ed_wr (.clk(clk), .reset(reset), .d_i(main_wr),
                      .rise_o(wr_rise_s), .fall_o(unused_fall_s));
    edge_det u_ed_ia (.clk(clk), .reset(reset), .d_i(intack),
                      .rise_o(ia_rise_s), .fall_o(unused_ia_fall_s));
    edge_det u_ed_na (.clk(clk), .reset(reset), .d_i(nmiack),
                      .rise_o(na_rise_s), .fall_o(unused_na_fall_s));
    edge_det u_ed_rd (.clk(clk), .reset(reset), .d_i(rd_sel_s),
                      .rise_o(unused_rise_s), .fall_o(rd_fall_s));

    // Divider next state and terminal-count tick.
    always_comb begin
        tick_s = 1'b0;
        cnt_d  = cnt_q;
        if (clk_en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = {CNT_W{1'b0}};
                tick_s = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Divider register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Periodic IRQ handshake; a tick outside IDLE is dropped and flagged.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IRQ_IDLE;
            intreq_q   <= 1'b0;
            irq_miss_q <= 1'b0;
        end else begin
            irq_miss_q <= 1'b0;
            case (state_q)
                IRQ_IDLE: begin
                    if (tick_s) begin
                        state_q  <= IRQ_REQ;
                        intreq_q <= 1'b1;
                    end
                end
                IRQ_REQ: begin
                    irq_miss_q <= tick_s;
                    if (ia_rise_s) begin
                        state_q  <= IRQ_ACK;
                        intreq_q <= 1'b0;
                    end
                end
                IRQ_ACK: begin
                    irq_miss_q <= tick_s;
                    // Wait for the acknowledge to drop so a long intack counts once.
                    if (!intack) begin
                        state_q <= IRQ_IDLE;
                    end
                end
                default: begin
                    state_q  <= IRQ_IDLE;
                    intreq_q <= 1'b0;
                end
            endcase
        end
    end

    // Command mailbox; a fresh write always beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_data_q    <= 8'h00;
            cmd_pending_q <= 1'b0;
            cmd_overrun_q <= 1'b0;
            nmireq_q      <= 1'b0;
        end else if (wr_rise_s) begin
            cmd_data_q    <= main_data;
            cmd_pending_q <= 1'b1;
            nmireq_q      <= 1'b1;
            if (cmd_pending_q) begin
                cmd_overrun_q <= 1'b1;
            end
        end else begin
            if (na_rise_s) begin
                nmireq_q <= 1'b0;
            end
            if (rd_fall_s) begin
                cmd_pending_q <= 1'b0;
                cmd_overrun_q <= 1'b0;
            end
        end
    end

    assign intreq      = intreq_q;
    assign irq_miss    = irq_miss_q;
    assign nmireq      = nmireq_q;
    assign cmd_oe      = rd_sel_s;
    assign cmd_data    = cmd_data_q;
    assign cmd_pending = cmd_pending_q;
    assign cmd_overrun = cmd_overrun_q;

endmodule

// File: tb/tb_sys1_snd_ctrl.sv
module tb_sys1_snd_ctrl;

    localparam int DIV = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_en = 1'b0;
    logic        main_wr = 1'b0;
    logic [7:0]  main_data = 8'h00;
    logic [15:0] snd_adr = 16'h0000;
    logic        snd_mx = 1'b0;
    logic        snd_rd = 1'b0;
    logic        intack = 1'b0;
    logic        nmiack = 1'b0;
    logic        intreq, nmireq, cmd_oe, cmd_pending, cmd_overrun, irq_miss;
    logic [7:0]  cmd_data;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit        m_pwr, m_pia, m_pna, m_prd;
    int        m_ticks;
    bit        m_intreq, m_wait_rel, m_miss;
    bit        m_nmi, m_pend, m_ovr;
    bit [7:0]  m_data;

    sys1_snd_ctrl #(.IRQ_DIV(DIV), .CMD_BASE(16'hE000), .CMD_MASK(16'hE000)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en),
        .main_wr(main_wr), .main_data(main_data),
        .snd_adr(snd_adr), .snd_mx(snd_mx), .snd_rd(snd_rd),
        .intack(intack), .nmiack(nmiack),
        .intreq(intreq), .nmireq(nmireq), .cmd_oe(cmd_oe),
        .cmd_data(cmd_data), .cmd_pending(cmd_pending),
        .cmd_overrun(cmd_overrun), .irq_miss(irq_miss)
    );

    always #5 clk = ~clk;

    function automatic bit rd_sel();
        return snd_mx && snd_rd && ((snd_adr & 16'hE000) == 16'hE000);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the currently applied inputs.
    task automatic model_edge();
        bit wr_e, ia_e, na_e, rd_f, tick, cur_rd;
        cur_rd = rd_sel();
        if (reset) begin
            m_pwr = 0; m_pia = 0; m_pna = 0; m_prd = 0;
            m_ticks = 0; m_intreq = 0; m_wait_rel = 0; m_miss = 0;
            m_nmi = 0; m_pend = 0; m_ovr = 0; m_data = 8'h00;
            return;
        end
        wr_e = main_wr && !m_pwr;
        ia_e = intack && !m_pia;
        na_e = nmiack && !m_pna;
        rd_f = !cur_rd && m_prd;
        tick = clk_en && (m_ticks == DIV - 1);
        if (clk_en) m_ticks = (m_ticks + 1) % DIV;
        m_miss = tick && (m_intreq || m_wait_rel);
        if (m_intreq && ia_e) begin
            m_intreq = 0; m_wait_rel = 1;
        end else if (m_wait_rel && !intack) begin
            m_wait_rel = 0;
        end else if (tick && !m_intreq && !m_wait_rel) begin
            m_intreq = 1;
        end
        if (wr_e) begin
            if (m_pend) m_ovr = 1;
            m_data = main_data; m_pend = 1; m_nmi = 1;
        end else begin
            if (na_e) m_nmi = 0;
            if (rd_f) begin m_pend = 0; m_ovr = 0; end
        end
        m_pwr = main_wr; m_pia = intack; m_pna = nmiack; m_prd = cur_rd;
    endtask

    // One clock: update model, clock DUT, compare every output.
    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        chk("intreq", intreq, m_intreq);
        chk("nmireq", nmireq, m_nmi);
        chk("cmd_pending", cmd_pending, m_pend);
        chk("cmd_overrun", cmd_overrun, m_ovr);
        chk("cmd_data", cmd_data, m_data);
        chk("irq_miss", irq_miss, m_miss);
        chk("cmd_oe", cmd_oe, rd_sel());
    endtask

    task automatic rd_bus(input logic [15:0] a, input bit on);
        snd_adr = a; snd_mx = on; snd_rd = on;
    endtask

    initial begin
        int n;
        int misses;
        bit seen;

        // Reset
        reset = 1'b1; clk_en = 1'b1;
        cyc(); cyc();
        chk("rst_intreq", intreq, 1'b0);
        chk("rst_cmd_data", cmd_data, 8'h00);
        reset = 1'b0;

        // First IRQ after DIV ticks
        n = 0; seen = 0;
        for (int i = 0; i < 4 * DIV && !seen; i++) begin
            cyc(); n++;
            if (intreq) seen = 1;
        end
        chk("first_irq_cycles", n, DIV);
        intack = 1'b1; cyc();
        chk("ack_clears_intreq", intreq, 1'b0);
        intack = 1'b0;
        n = 1; seen = 0;
        for (int i = 0; i < 4 * DIV && !seen; i++) begin
            cyc(); n++;
            if (intreq) seen = 1;
        end
        chk("irq_period", n, DIV);
        intack = 1'b1; cyc(); intack = 1'b0; cyc();

        // Single write, NMI ack, read
        main_wr = 1'b1; main_data = 8'h5A; cyc();
        chk("wr_nmireq", nmireq, 1'b1);
        chk("wr_pending", cmd_pending, 1'b1);
        chk("wr_data", cmd_data, 8'h5A);
        main_wr = 1'b0; cyc();
        nmiack = 1'b1; cyc();
        chk("nmiack_clears", nmireq, 1'b0);
        nmiack = 1'b0;
        rd_bus(16'hE000, 1'b1); cyc();
        chk("rd_oe", cmd_oe, 1'b1);
        chk("rd_pending_held", cmd_pending, 1'b1);
        rd_bus(16'hE000, 1'b0); cyc();
        chk("rd_clears_pending", cmd_pending, 1'b0);
        chk("rd_keeps_data", cmd_data, 8'h5A);

        // Overrun
        main_wr = 1'b1; main_data = 8'h11; cyc(); main_wr = 1'b0; cyc();
        main_wr = 1'b1; main_data = 8'h22; cyc(); main_wr = 1'b0; cyc();
        chk("ovr_data", cmd_data, 8'h22);
        chk("ovr_flag", cmd_overrun, 1'b1);
        rd_bus(16'hE001, 1'b1); cyc(); rd_bus(16'hE001, 1'b0); cyc();
        chk("ovr_rd_pending", cmd_pending, 1'b0);
        chk("ovr_rd_flag", cmd_overrun, 1'b0);

        // Write beats same-cycle nmiack and read fall
        rd_bus(16'hE000, 1'b1); cyc();
        rd_bus(16'hE000, 1'b0); nmiack = 1'b1; main_wr = 1'b1; main_data = 8'h33; cyc();
        chk("coll_nmireq", nmireq, 1'b1);
        chk("coll_pending", cmd_pending, 1'b1);
        chk("coll_data", cmd_data, 8'h33);
        nmiack = 1'b0; main_wr = 1'b0; cyc();

        // Withheld intack: exactly three dropped ticks
        intack = 1'b1; cyc(); intack = 1'b0; cyc();
        seen = 0;
        for (int i = 0; i < 4 * DIV && !seen; i++) begin
            cyc();
            if (intreq) seen = 1;
        end
        chk("wait_irq", seen, 1'b1);
        misses = 0;
        for (int i = 0; i < 3 * DIV; i++) begin
            cyc();
            if (irq_miss) misses++;
        end
        chk("miss_count", misses, 3);
        chk("miss_intreq_held", intreq, 1'b1);
        rd_bus(16'h6000, 1'b1); cyc();
        chk("rd_6000_oe", cmd_oe, 1'b0);
        rd_bus(16'h6000, 1'b0); cyc();

        // Reset while both requests are active
        main_wr = 1'b1; main_data = 8'hC3; cyc(); main_wr = 1'b0;
        chk("pre_rst_intreq", intreq, 1'b1);
        chk("pre_rst_nmireq", nmireq, 1'b1);
        reset = 1'b1; cyc();
        chk("mid_rst_intreq", intreq, 1'b0);
        chk("mid_rst_nmireq", nmireq, 1'b0);
        chk("mid_rst_data", cmd_data, 8'h00);
        reset = 1'b0;
        n = 0; seen = 0;
        for (int i = 0; i < 4 * DIV && !seen; i++) begin
            cyc(); n++;
            if (intreq) seen = 1;
        end
        chk("post_rst_irq_cycles", n, DIV);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(0, 149) == 0);
            clk_en    = ($urandom_range(0, 3) != 0);
            main_wr   = ($urandom_range(0, 5) == 0);
            main_data = 8'($urandom);
            snd_adr   = ($urandom_range(0, 1) == 0) ? (16'hE000 | 16'($urandom_range(0, 8191)))
                                                    : 16'($urandom);
            snd_mx    = ($urandom_range(0, 2) != 0);
            snd_rd    = ($urandom_range(0, 2) != 0);
            intack    = ($urandom_range(0, 3) == 0);
            nmiack    = ($urandom_range(0, 3) == 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
